ps2_keyboard_rx_fifo: RTL and testbench

//  System-clocked PS/2 keyboard receiver. Successor to the ps2_clk-driven keyboard controller.

---
 rtl/ps2_keyboard_rx_fifo.sv | 153 +++++++++++++++
 tb/tb_ps2_keyboard_rx_fifo.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard_rx_fifo.sv
// ps2_keyboard_rx_fifo: system-clocked PS/2 keyboard receiver with E0/F0 decode and key-event FIFO
// Oversamples ps2_clk/ps2_data, frames 11-bit packets (start, 8 data LSB first, odd parity, stop),
// folds E0/F0 prefixes into {extended, release, code} events and buffers them show-ahead.
// Optional: define KBD_TYPEMATIC_FILTER_EN to drop auto-repeated make events.
// Ports:
//   clk, reset                synchronous active-high reset
//   ps2_clk, ps2_data         raw async keyboard lines (idle high)
//   rd_en                     pop FIFO head (ignored when empty)
//   key_valid/key_code/key_release/key_extended   FIFO head event
//   fifo_count                entries held
//   overflow, parity_err, frame_err               one-cycle error pulses
module ps2_keyboard_rx_fifo #(
  parameter int DEPTH          = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ps2_clk,
  input  logic                       ps2_data,
  input  logic                       rd_en,
  output logic                       key_valid,
  output logic [7:0]                 key_code,
  output logic                       key_release,
  output logic                       key_extended,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       overflow,
  output logic                       parity_err,
  output logic                       frame_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
  logic clk_prev_q, fall, bit_in, timeout;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic par_q, par_d;
  logic ext_q, ext_d, brk_q, brk_d;
  logic byte_done, good, par_bad, frame_bad, err, is_e0, is_f0, evt, push;
  logic [9:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] count_q, count_d;
  logic pop, full, wr;
  logic overflow_q, parity_err_q, frame_err_q;
  assign bit_in  = data_sync_q[SYNC_STAGES-1];
  assign fall    = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
  assign timeout = (state_q != IDLE) && !fall && (tmo_q == TW'(TIMEOUT_CYCLES-1));
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
      state_q     <= IDLE;
      tmo_q       <= '0;
      cnt_q       <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      wp_q        <= '0;
      rp_q        <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
      clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      count_q     <= count_d;
      overflow_q  <= push && full && !pop;
      parity_err_q <= par_bad;
      frame_err_q <= frame_bad;
    end
  end
  always_comb begin
    state_d = state_q;
    if (timeout) state_d = IDLE;
    else if (fall) begin
      case (state_q)
        IDLE:    state_d = bit_in ? IDLE : DATA;
        DATA:    state_d = (cnt_q == 3'd7) ? PARITY : DATA;
        PARITY:  state_d = STOP;
        default: state_d = IDLE;
      endcase
    end
  end
  always_comb begin
    byte_done = (state_q == STOP) && fall && bit_in;
    frame_bad = (fall && (((state_q == IDLE) && bit_in) || ((state_q == STOP) && !bit_in))) || timeout;
    good      = byte_done && ^{shift_q, par_q};
    par_bad   = byte_done && !(^{shift_q, par_q});
    err       = par_bad || frame_bad;
    shift_d   = ((state_q == DATA) && fall) ? {bit_in, shift_q[7:1]} : shift_q;
    cnt_d     = (state_q == DATA) ? cnt_q + 3'(fall) : 3'd0;
    par_d     = ((state_q == PARITY) && fall) ? bit_in : par_q;
    tmo_d     = ((state_q == IDLE) || fall) ? '0 : tmo_q + TW'(1);
  end
  assign is_e0 = shift_q == 8'hE0;
  assign is_f0 = shift_q == 8'hF0;
  assign evt   = good && !is_e0 && !is_f0;
  assign ext_d = err ? 1'b0 : good ? (is_e0 | (is_f0 & ext_q)) : ext_q;
  assign brk_d = err ? 1'b0 : good ? (is_f0 | (is_e0 & brk_q)) : brk_q;
`ifdef KBD_TYPEMATIC_FILTER_EN
  logic [8:0] last_q;
  logic last_v_q;
  logic same_key;
  assign same_key = last_q == {ext_q, shift_q};
  // A repeated make of the held key is swallowed; its break re-arms the filter.
  assign push = evt && !(!brk_q && last_v_q && same_key);
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q   <= '0;
      last_v_q <= 1'b0;
    end else if (evt) begin
      last_q   <= brk_q ? last_q : {ext_q, shift_q};
      last_v_q <= brk_q ? (last_v_q && !same_key) : 1'b1;
    end
  end
`else
  assign push = evt;
`endif
  assign pop     = rd_en && key_valid;
  assign full    = count_q == CW'(DEPTH);
  assign wr      = push && (!full || pop);
  assign wp_d    = wp_q + AW'(wr);
  assign rp_d    = rp_q + AW'(pop);
  assign count_d = count_q + CW'(wr) - CW'(pop);
  always_ff @(posedge clk) begin
    if (wr) mem_q[wp_q] <= {ext_q, brk_q, shift_q};
  end
  assign key_valid    = count_q != '0;
  assign key_code     = key_valid ? mem_q[rp_q][7:0] : 8'h00;
  assign key_release  = key_valid && mem_q[rp_q][8];
  assign key_extended = key_valid && mem_q[rp_q][9];
  assign fifo_count   = count_q;
  assign overflow     = overflow_q;
  assign parity_err   = parity_err_q;
  assign frame_err    = frame_err_q;
endmodule

// File: tb/tb_ps2_keyboard_rx_fifo.sv
// tb_ps2_keyboard_rx_fifo: directed bench for the PS/2 receiver and key-event FIFO
module tb_ps2_keyboard_rx_fifo;
  localparam int HALF = 40;
  localparam int TMO = 5000;
  logic clk = 1'b0, reset = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1, rd_en = 1'b0;
  logic key_valid, key_release, key_extended, overflow, parity_err, frame_err;
  logic [7:0] key_code;
  logic [2:0] fifo_count;
  int pass_n = 0, total_n = 0, pe_n = 0, fe_n = 0, ov_n = 0, lat;
  ps2_keyboard_rx_fifo #(.DEPTH(4), .SYNC_STAGES(2), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd_en(rd_en),
    .key_valid(key_valid), .key_code(key_code), .key_release(key_release),
    .key_extended(key_extended), .fifo_count(fifo_count), .overflow(overflow),
    .parity_err(parity_err), .frame_err(frame_err));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (parity_err) pe_n++;
    if (frame_err) fe_n++;
    if (overflow) ov_n++;
  end
  task automatic send_bit(input logic v);
    @(negedge clk) ps2_data = v;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask
  task automatic send_frame(input logic [7:0] b, input logic flip, input logic pop_sync);
    logic [9:0] f;
    f = {(~^b) ^ flip, b, 1'b0};
    for (int i = 0; i < 10; i++) send_bit(f[i]);
    @(negedge clk) ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    lat = -1;
    if (pop_sync) begin
      @(posedge clk);
      @(posedge clk);
      @(negedge clk) rd_en = 1'b1;
      @(negedge clk) rd_en = 1'b0;
      repeat (HALF-2) @(negedge clk);
    end else begin
      for (int k = 1; k <= HALF; k++) begin
        @(negedge clk);
        if (key_valid && lat < 0) lat = k;
      end
    end
    ps2_clk = 1'b1;
  endtask
  task automatic pop();
    @(negedge clk) rd_en = 1'b1;
    @(negedge clk) rd_en = 1'b0;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total_n++; if (key_code !== 8'h00) $display("FAIL reset_code got %h exp 00", key_code); else pass_n++;
    total_n++;
    if ({key_valid, key_release, key_extended, fifo_count, overflow, parity_err, frame_err} !== 9'b0)
      $display("FAIL reset_outs got %b exp 0", {key_valid, key_release, key_extended, fifo_count, overflow, parity_err, frame_err});
    else pass_n++;
    reset = 1'b0;
    repeat (5) @(negedge clk);
  endtask
  task automatic test_single();
    send_frame(8'h1C, 1'b0, 1'b0);
    total_n++; if (lat < 1 || lat > 4) $display("FAIL t1_latency got %0d exp 1..4", lat); else pass_n++;
    total_n++;
    if ({key_valid, key_code, key_release, key_extended, fifo_count} !== {1'b1, 8'h1C, 2'b00, 3'd1})
      $display("FAIL t1_head got v=%b %h r=%b e=%b n=%0d exp v=1 1C r=0 e=0 n=1", key_valid, key_code, key_release, key_extended, fifo_count);
    else pass_n++;
    pop();
    total_n++; if (fifo_count !== 3'd0) $display("FAIL t1_pop got %0d exp 0", fifo_count); else pass_n++;
  endtask
  task automatic test_prefix();
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    total_n++; if (fifo_count !== 3'd2) $display("FAIL t2_count got %0d exp 2", fifo_count); else pass_n++;
    total_n++; if ({key_extended, key_release, key_code} !== {2'b01, 8'h1C}) $display("FAIL t2_first got %h exp 11C", {key_extended, key_release, key_code}); else pass_n++;
    pop();
    total_n++; if ({key_extended, key_release, key_code} !== {2'b11, 8'h75}) $display("FAIL t2_second got %h exp 375", {key_extended, key_release, key_code}); else pass_n++;
    pop();
    total_n++; if (key_valid !== 1'b0) $display("FAIL t2_empty got %b exp 0", key_valid); else pass_n++;
    pop();
    total_n++; if (fifo_count !== 3'd0) $display("FAIL t2_empty_pop got %0d exp 0", fifo_count); else pass_n++;
  endtask
  task automatic test_parity();
    int p0;
    p0 = pe_n;
    send_frame(8'h1C, 1'b1, 1'b0);
    total_n++; if (pe_n - p0 != 1) $display("FAIL t3_parity_pulse got %0d exp 1", pe_n - p0); else pass_n++;
    total_n++; if (fifo_count !== 3'd0) $display("FAIL t3_dropped got %0d exp 0", fifo_count); else pass_n++;
    send_frame(8'h1B, 1'b0, 1'b0);
    total_n++; if ({key_valid, key_release, key_code} !== {2'b10, 8'h1B}) $display("FAIL t3_next got %h exp 21B", {key_valid, key_release, key_code}); else pass_n++;
    pop();
  endtask
  task automatic test_timeout();
    int f0;
    f0 = fe_n;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    repeat (4000) @(negedge clk);
    total_n++; if (fe_n - f0 != 0) $display("FAIL t4_early got %0d exp 0", fe_n - f0); else pass_n++;
    repeat (1200) @(negedge clk);
    total_n++; if (fe_n - f0 != 1) $display("FAIL t4_timeout got %0d exp 1", fe_n - f0); else pass_n++;
    total_n++; if (fifo_count !== 3'd0) $display("FAIL t4_count got %0d exp 0", fifo_count); else pass_n++;
    send_frame(8'h2D, 1'b0, 1'b0);
    total_n++; if ({key_valid, key_extended, key_release, key_code} !== {3'b100, 8'h2D}) $display("FAIL t4_next got %h exp 42D", {key_valid, key_extended, key_release, key_code}); else pass_n++;
    pop();
  endtask
  task automatic test_overflow();
    logic [7:0] k [5];
    int o0;
    k = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
    o0 = ov_n;
    for (int i = 0; i < 5; i++) send_frame(k[i], 1'b0, 1'b0);
    total_n++; if (fifo_count !== 3'd4) $display("FAIL t5_full got %0d exp 4", fifo_count); else pass_n++;
    total_n++; if (ov_n - o0 != 1) $display("FAIL t5_overflow got %0d exp 1", ov_n - o0); else pass_n++;
    for (int i = 0; i < 4; i++) begin
      total_n++; if (key_code !== k[i]) $display("FAIL t5_drain%0d got %h exp %h", i, key_code, k[i]); else pass_n++;
      pop();
    end
    for (int i = 0; i < 4; i++) send_frame(k[i], 1'b0, 1'b0);
    o0 = ov_n;
    send_frame(k[4], 1'b0, 1'b1);
    total_n++; if (fifo_count !== 3'd4) $display("FAIL t5_popush_count got %0d exp 4", fifo_count); else pass_n++;
    total_n++; if (ov_n - o0 != 0) $display("FAIL t5_popush_ovf got %0d exp 0", ov_n - o0); else pass_n++;
    for (int i = 1; i < 5; i++) begin
      total_n++; if (key_code !== k[i]) $display("FAIL t5_redrain%0d got %h exp %h", i, key_code, k[i]); else pass_n++;
      pop();
    end
  endtask
  task automatic test_typematic();
    logic [7:0] s [6];
    logic [9:0] e [4];
    int n, o0;
    s = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};
`ifdef KBD_TYPEMATIC_FILTER_EN
    e = '{10'h01C, 10'h11C, 10'h01C, 10'h000};
    n = 3;
`else
    e = '{10'h01C, 10'h01C, 10'h01C, 10'h11C};
    n = 4;
`endif
    o0 = ov_n;
    for (int i = 0; i < 6; i++) send_frame(s[i], 1'b0, 1'b0);
    total_n++; if (int'(fifo_count) != n) $display("FAIL t6_count got %0d exp %0d", fifo_count, n); else pass_n++;
    total_n++; if (ov_n - o0 != n - 3) $display("FAIL t6_overflow got %0d exp %0d", ov_n - o0, n - 3); else pass_n++;
    for (int i = 0; i < n; i++) begin
      total_n++; if ({key_extended, key_release, key_code} !== e[i]) $display("FAIL t6_entry%0d got %h exp %h", i, {key_extended, key_release, key_code}, e[i]); else pass_n++;
      pop();
    end
  endtask
  task automatic test_reset_mid();
    send_frame(8'hE0, 1'b0, 1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    @(negedge clk) reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    total_n++; if ({key_valid, fifo_count} !== 4'b0) $display("FAIL t7_reset got %b exp 0", {key_valid, fifo_count}); else pass_n++;
    repeat (HALF) @(negedge clk);
    send_frame(8'h1C, 1'b0, 1'b0);
    total_n++; if ({key_valid, key_extended, key_release, key_code} !== {3'b100, 8'h1C}) $display("FAIL t7_clean got %h exp 41C", {key_valid, key_extended, key_release, key_code}); else pass_n++;
    pop();
  endtask
  initial begin
    test_reset();
    test_single();
    test_prefix();
    test_parity();
    test_timeout();
    test_overflow();
    test_typematic();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
